// File: rtl/response_sender.sv
// response_sender: serialises a two-byte response (code, then data) into a UART
// transmitter using a start/busy/done handshake, with an optional inter-byte gap
// and a per-byte timeout that aborts the transfer.
module response_sender #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned BYTE_GAP       = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       send_request,
    input  logic [7:0] response_code,
    input  logic [7:0] response_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       response_sent,
    output logic       timeout_error
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GapW   = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;

    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StStartCode,
        StWaitCode,
        StGap,
        StStartData,
        StWaitData,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        code_q, code_d;
    logic [7:0]        data_q, data_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              sent_q, sent_d;
    logic              timeout_q, timeout_d;

    // Next-state and registered-output logic for the send sequence.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        data_d     = data_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        sent_d     = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            StIdle: begin
                // busy still high means we just returned here: drop it this cycle
                // and only accept a new request once it is low.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (send_request) begin
                    code_d  = response_code;
                    data_d  = response_data;
                    busy_d  = 1'b1;
                    state_d = StStartCode;
                end
            end

            StStartCode: begin
                if (!tx_busy) begin
                    tx_data_d  = code_q;
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                    state_d    = StWaitCode;
                end
            end

            StWaitCode: begin
                // done takes priority over a coincident timeout
                if (tx_done) begin
                    gap_d   = '0;
                    state_d = (BYTE_GAP == 0) ? StStartData : StGap;
                end else if (timer_q == TimerLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StStartData;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            StStartData: begin
                if (!tx_busy) begin
                    tx_data_d  = data_q;
                    tx_start_d = 1'b1;
                    timer_d    = '0;
                    state_d    = StWaitData;
                end
            end

            StWaitData: begin
                if (tx_done) begin
                    state_d = StFinish;
                end else if (timer_q == TimerLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StFinish: begin
                sent_d  = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            code_q     <= 8'h00;
            data_q     <= 8'h00;
            timer_q    <= '0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            data_q     <= data_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_start      = tx_start_q;
    assign tx_data       = tx_data_q;
    assign busy          = busy_q;
    assign response_sent = sent_q;
    assign timeout_error = timeout_q;

endmodule

// File: doc/response_sender.md
# response_sender

Transmit-side counterpart of the request decoder. Takes a two-byte response (response code, sensor data byte) from the sensor decoding logic and serialises it, byte by byte, into the UART transmitter through a start/busy/done handshake. It guarantees the byte order code-then-data, enforces an optional inter-byte gap, and aborts with an error pulse if the transmitter stalls.

## Interface
- TIMEOUT_CYCLES, default 1_000_000: maximum cycles to wait for `tx_done` after each `tx_start`; counter width is $clog2(TIMEOUT_CYCLES+1).
- BYTE_GAP, default 0: idle cycles inserted between the first byte's `tx_done` and the second byte's `tx_start`.
- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- send_request  in  1  level; request to send one response.
- response_code  in  8  first byte; sampled on acceptance.
- response_data  in  8  second byte; sampled on acceptance.
- tx_busy  in  1  UART transmitter busy.
- tx_done  in  1  one-cycle pulse, UART transmitter finished a byte.
- tx_start  out  1  one-cycle pulse, load `tx_data` into the transmitter.
- tx_data  out  8  byte presented to the transmitter.
- busy  out  1  high from acceptance until return to IDLE.
- response_sent  out  1  one-cycle pulse, both bytes transmitted.
- timeout_error  out  1  one-cycle pulse, transfer aborted.

## Operation
- States: IDLE, START_CODE, WAIT_CODE, GAP, START_DATA, WAIT_DATA, FINISH.
- IDLE: `send_request`=1 latches `response_code`/`response_data` into internal registers, goes to START_CODE, `busy`<=1.
- START_CODE: if `tx_busy`=0, `tx_data`<=code, `tx_start`<=1 (one cycle), timer<=0, go WAIT_CODE; if `tx_busy`=1 stay (no timeout here).
- WAIT_CODE: `tx_done`=1 -> GAP (gap counter<=0), or START_DATA directly if BYTE_GAP=0. Otherwise timer increments; at timer = TIMEOUT_CYCLES-1 without `tx_done`: `timeout_error` pulse, go IDLE.
- GAP: counts BYTE_GAP cycles, then START_DATA.
- START_DATA / WAIT_DATA: identical to code phase with `tx_data`<=latched data byte; WAIT_DATA `tx_done` -> FINISH.
- FINISH: `response_sent` pulse, go IDLE.
- `send_request` outside IDLE is ignored (not queued); input byte changes after acceptance have no effect.
- `tx_done` outside WAIT_CODE/WAIT_DATA is ignored; `tx_done` coinciding with timeout expiry counts as done (done wins).
- `tx_data` holds the last byte driven until next `tx_start`.
- Reset (any state, any time): state IDLE, `tx_start`=0, `tx_data`=8'h00, `busy`=0, `response_sent`=0, `timeout_error`=0, timers and latched bytes 0; an in-flight response is dropped.

## Timing
- All outputs registered.
- `send_request` sampled high at edge N with `tx_busy`=0: `busy` high from N, first `tx_start` high in cycle following edge N+1.
- `tx_done` sampled at edge M in WAIT_CODE: second `tx_start` high in cycle following edge M+1+BYTE_GAP.
- `tx_done` sampled at edge K in WAIT_DATA: `response_sent` high in cycle following edge K+1; `busy` low the cycle after.
- Earliest next acceptance: edge after `busy` falls; back-to-back requests need one IDLE cycle.
- `tx_start` never asserted while `tx_busy`=1 as sampled on the same edge.
- Timeout: `timeout_error` asserted TIMEOUT_CYCLES cycles after the `tx_start` cycle; `busy` low on the next cycle.

## Test plan
- Basic: code=8'h01, data=8'h1A, BYTE_GAP=0, transmitter model returns `tx_done` 10 cycles after each start -> `tx_data` sequence 8'h01 then 8'h1A, exactly two `tx_start` pulses, one `response_sent`, `timeout_error` never.
- Busy stall: `tx_busy`=1 for 20 cycles at acceptance -> no `tx_start` until the cycle after `tx_busy` falls, then normal completion.
- Gap: BYTE_GAP=5 -> second `tx_start` exactly 6 cycles after first `tx_done` sampled edge.
- Timeout: TIMEOUT_CYCLES=16, no `tx_done` after the first byte -> `timeout_error` pulse 16 cycles after `tx_start`, no second `tx_start`, no `response_sent`, `busy` drops.
- Ignored inputs: `send_request` re-asserted with code=8'hFF mid-transfer and spurious `tx_done` in IDLE -> original bytes sent once, no extra transfer, no state change.
- Reset mid-transfer: `reset_n` low during WAIT_DATA -> all outputs zero immediately; after release, a new request (8'h02, 8'h33) completes normally.
